main_graphic_frame_scheduler: RTL
=================================

Name: main_graphic_frame_scheduler

Overview:
- Owns the 64-bit MainGraphic frame that feeds the 8x8 LED matrix row scanner.
- Two requesters share a back buffer through a row-write arbiter: the game engine (gm) and the score/text overlay (ov).
- Commits the back buffer to the front buffer only at a scan frame boundary, so the display never tears.
- Generates the row-scan tick and the frame-boundary timing, and applies an optional whole-frame blink.

Parameters:
- SCAN_DIV, 2500: clk cycles per scanned row (scan_tick period); legal range is 2 or more.
- BLINK_FRAMES, 32: frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- gm_req  in  1  game row-write request; held until granted
- gm_row  in  3  game target row (0 = top)
- gm_data  in  8  game row pixels
- gm_gnt  out  1  one-cycle grant; write occurs on this cycle's edge
- ov_req  in  1  overlay row-write request
- ov_row  in  3  overlay target row
- ov_data  in  8  overlay row pixels
- ov_gnt  out  1  one-cycle overlay grant
- swap_req  in  1  pulse: publish back buffer at next frame boundary
- swap_busy  out  1  high while a swap is pending
- swap_done  out  1  one-cycle pulse when front buffer updated
- blink_en  in  1  enable blink of displayed frame
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles
- row_idx  out  3  row currently scanned
- frame_start  out  1  one-cycle pulse coincident with scan_tick when row_idx wraps 7->0
- MainGraphic  out  64  displayed frame, row r at bits [63-8r : 56-8r]

Behaviour:
- Reset (asynchronous, rst_n=0) clears the following, all immediately:
  - back and front buffers, and MainGraphic: 0
  - gm_gnt, ov_gnt, swap_busy, swap_done, scan_tick, frame_start: 0
  - row_idx, prescaler, blink counter: 0
  - FSM: IDLE; round-robin pointer: gm
- Any in-flight swap is lost on reset.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - scan_tick=1 on the cycle the count equals SCAN_DIV-1, then the count wraps to 0.
  - row_idx increments on the same edge and wraps 7->0.
  - frame_start=1 on the scan_tick cycle where row_idx==7.
- Arbiter (FSM state IDLE only; both gnt held 0 in PENDING):
  - A single requester is granted the cycle after its req is sampled high.
  - When both request, grant goes to the round-robin pointer's side; the pointer then flips to the other side.
  - Grants are never back-to-back to the same requester while the other is waiting.
  - At most one gnt is high per cycle.
  - A granted write replaces back-buffer row <row> with <data> at that edge.
  - A requester that still has req high after its gnt is treated as a new request.
- Swap FSM, states IDLE, PENDING:
  - IDLE with swap_req=1 -> PENDING, swap_busy=1. A write granted in that same cycle still completes.
  - PENDING with frame_start=1: front<=back, swap_done=1 for one cycle, -> IDLE, swap_busy=0. The back buffer is retained, not cleared.
  - swap_req while PENDING is ignored.
  - swap_req coinciding with frame_start in IDLE enters PENDING; the swap happens at the next frame_start, not the current one.
- Blink:
  - The counter advances on each frame_start and wraps at 2*BLINK_FRAMES-1.
  - MainGraphic = 0 when blink_en=1 and counter >= BLINK_FRAMES; otherwise MainGraphic = front buffer.
  - MainGraphic is registered: it updates one cycle after a front-buffer or blink change.
  - Deasserting blink_en restores the frame on the next cycle. The counter keeps running either way.

Test Plan:
(SCAN_DIV=4, BLINK_FRAMES=2)
- Reset release: all outputs 0. First scan_tick at cycle 4. frame_start at the 8th scan_tick (cycle 32), then every 32 cycles. row_idx sequence is 1..7,0.
- gm writes row0=8'hA5 then swap_req: MainGraphic stays 0 until frame_start. One cycle after swap_done, MainGraphic=64'hA500_0000_0000_0000.
- gm_req and ov_req both held high (rows 3 and 7): grants alternate gm,ov,gm,ov and never overlap. Last-written values appear in bytes [39:32] and [7:0] after the swap.
- swap_req pulsed during PENDING, and gm_req asserted during PENDING: exactly one swap_done; no gm_gnt until after swap_done.
- blink_en=1 with front=64'hFFFF_FFFF_FFFF_FFFF: MainGraphic alternates all-ones/zero every 2 frames (64 cycles).
- rst_n pulled low mid-PENDING: all outputs 0 immediately. After release, no swap_done occurs at the next frame_start.

Source files
------------

// File: rtl/main_graphic_frame_scheduler_if.sv
// Row-write, swap, scan-timing and frame bundle between requesters and the frame scheduler.
// Master drives requests/pixels and blink enable; slave returns grants, swap status, scan timing and the frame.
interface main_graphic_frame_scheduler_if;
    logic        gm_req;
    logic [2:0]  gm_row;
    logic [7:0]  gm_data;
    logic        gm_gnt;
    logic        ov_req;
    logic [2:0]  ov_row;
    logic [7:0]  ov_data;
    logic        ov_gnt;
    logic        swap_req;
    logic        swap_busy;
    logic        swap_done;
    logic        blink_en;
    logic        scan_tick;
    logic [2:0]  row_idx;
    logic        frame_start;
    logic [63:0] MainGraphic;

    modport master (
        output gm_req, gm_row, gm_data, ov_req, ov_row, ov_data, swap_req, blink_en,
        input  gm_gnt, ov_gnt, swap_busy, swap_done, scan_tick, row_idx, frame_start, MainGraphic
    );

    modport slave (
        input  gm_req, gm_row, gm_data, ov_req, ov_row, ov_data, swap_req, blink_en,
        output gm_gnt, ov_gnt, swap_busy, swap_done, scan_tick, row_idx, frame_start, MainGraphic
    );
endinterface

// File: rtl/main_graphic_frame_scheduler.sv
// Tear-free 8x8 frame owner: round-robin row writes into a back buffer, swap on frame boundary, blink.
// Grant 1 cycle after req, frame 1 cycle after front/blink change; requesters hold req until gnt, none in PENDING.
module main_graphic_frame_scheduler #(
    parameter int SCAN_DIV     = 2500,
    parameter int BLINK_FRAMES = 32
) (
    input logic                          clk,
    input logic                          rst_n,
    main_graphic_frame_scheduler_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(2 * BLINK_FRAMES);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q;
    logic [2:0]    row_q;
    logic [BW-1:0] blink_q;
    logic          gm_gnt_q, ov_gnt_q, gm_gnt_d, ov_gnt_d;
    logic          ptr_ov_q, ptr_ov_d;
    logic          gm_elig, ov_elig;
    logic [63:0]   back_q, front_q, mg_q;
    logic          done_q;
    logic          scan_tick, frame_start;

    assign scan_tick   = (pre_q == PRE_LAST);
    assign frame_start = scan_tick && (row_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            row_q   <= '0;
            blink_q <= '0;
        end else begin
            pre_q <= scan_tick ? '0 : pre_q + 1'b1;
            if (scan_tick)
                row_q <= row_q + 3'd1;
            if (frame_start)
                blink_q <= (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        end
    end

    // A requester whose grant is showing this cycle is not eligible again until the next sample,
    // which is what keeps two held requests alternating.
    always_comb begin
        state_d  = state_q;
        gm_gnt_d = 1'b0;
        ov_gnt_d = 1'b0;
        ptr_ov_d = ptr_ov_q;
        gm_elig  = 1'b0;
        ov_elig  = 1'b0;
        case (state_q)
            IDLE:    if (bus.swap_req) state_d = PENDING;
            PENDING: if (frame_start)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && !bus.swap_req) begin
            gm_elig = bus.gm_req && !gm_gnt_q;
            ov_elig = bus.ov_req && !ov_gnt_q;
            if (gm_elig && ov_elig) begin
                gm_gnt_d = !ptr_ov_q;
                ov_gnt_d = ptr_ov_q;
                ptr_ov_d = !ptr_ov_q;
            end else begin
                gm_gnt_d = gm_elig;
                ov_gnt_d = ov_elig;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gm_gnt_q <= 1'b0;
            ov_gnt_q <= 1'b0;
            ptr_ov_q <= 1'b0;
            back_q   <= '0;
            front_q  <= '0;
            done_q   <= 1'b0;
            mg_q     <= '0;
        end else begin
            state_q  <= state_d;
            gm_gnt_q <= gm_gnt_d;
            ov_gnt_q <= ov_gnt_d;
            ptr_ov_q <= ptr_ov_d;
            // Row r lives at bits [63-8r -: 8], i.e. byte offset (7-r)*8.
            if (gm_gnt_q)
                back_q[{~bus.gm_row, 3'b000} +: 8] <= bus.gm_data;
            if (ov_gnt_q)
                back_q[{~bus.ov_row, 3'b000} +: 8] <= bus.ov_data;
            if (state_q == PENDING && frame_start)
                front_q <= back_q;
            done_q <= (state_q == PENDING) && frame_start;
            mg_q   <= (bus.blink_en && (blink_q >= BLINK_HALF)) ? '0 : front_q;
        end
    end

    assign bus.gm_gnt      = gm_gnt_q;
    assign bus.ov_gnt      = ov_gnt_q;
    assign bus.swap_busy   = (state_q == PENDING);
    assign bus.swap_done   = done_q;
    assign bus.scan_tick   = scan_tick;
    assign bus.row_idx     = row_q;
    assign bus.frame_start = frame_start;
    assign bus.MainGraphic = mg_q;
endmodule
